// File: rtl/neighbor_bank_arbiter.sv
// neighbor_bank_arbiter
// Shares NUM_BANKS neighbor-memory banks among NUM_REQ request streams.
// Each bank runs its own round-robin arbitration over the requesters that
// address it, subject to a minimum issue spacing (BANK_LAT) and an external
// busy flag. Granted requests leave as registered per-bank commands.
//
// Ports:
//   clk            clock, all state updates on posedge
//   reset          asynchronous active-low reset
//   req_valid      per-requester request present
//   req_addr       per-requester {bank, row} address, ADDR_W bits each
//   req_tag        per-requester PE tag, TAG_W bits each
//   req_ready      per-requester grant (combinational from registered state + inputs)
//   Bank_busy      per-bank external busy flag
//   bank_cmd_valid per-bank registered one-cycle command strobe
//   bank_cmd_row   per-bank row of the last command
//   bank_cmd_tag   per-bank PE tag of the last command
//   bank_cmd_src   per-bank index of the requester that was granted
//   idle           no command strobe active and all occupancy counters zero
module neighbor_bank_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned TAG_W     = 2,
    parameter int unsigned BANK_LAT  = 2
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic [NUM_REQ-1:0]                                   req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]                            req_addr,
    input  logic [NUM_REQ*TAG_W-1:0]                             req_tag,
    output logic [NUM_REQ-1:0]                                   req_ready,
    input  logic [NUM_BANKS-1:0]                                 Bank_busy,
    output logic [NUM_BANKS-1:0]                                 bank_cmd_valid,
    output logic [NUM_BANKS*(ADDR_W-$clog2(NUM_BANKS))-1:0]      bank_cmd_row,
    output logic [NUM_BANKS*TAG_W-1:0]                           bank_cmd_tag,
    output logic [NUM_BANKS*$clog2(NUM_REQ)-1:0]                 bank_cmd_src,
    output logic                                                 idle
);

    localparam int unsigned BANK_W = $clog2(NUM_BANKS);
    localparam int unsigned ROW_W  = ADDR_W - BANK_W;
    localparam int unsigned SRC_W  = $clog2(NUM_REQ);
    localparam int unsigned OCC_W  = $clog2(BANK_LAT) + 1;

    localparam logic [OCC_W-1:0] OCC_RELOAD = OCC_W'(BANK_LAT - 1);
    localparam logic [SRC_W-1:0] SRC_LAST   = SRC_W'(NUM_REQ - 1);

    // Per-requester field decode
    logic [BANK_W-1:0] req_bank  [NUM_REQ];
    logic [ROW_W-1:0]  req_row   [NUM_REQ];
    logic [TAG_W-1:0]  req_tag_a [NUM_REQ];

    // Per-bank state and arbitration results
    logic [OCC_W-1:0]     occ_cnt   [NUM_BANKS];
    logic [SRC_W-1:0]     rr_ptr    [NUM_BANKS];
    logic [NUM_BANKS-1:0] bank_elig;
    logic [NUM_BANKS-1:0] grant_vld;
    logic [SRC_W-1:0]     grant_src [NUM_BANKS];

    // Split each request address into bank select (upper bits) and row (lower bits)
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_decode
        assign req_bank[i]  = req_addr[i*ADDR_W + ROW_W +: BANK_W];
        assign req_row[i]   = req_addr[i*ADDR_W +: ROW_W];
        assign req_tag_a[i] = req_tag[i*TAG_W +: TAG_W];
    end

    // A bank may grant only out of reset, when not busy and its spacing window has expired
    always_comb begin
        bank_elig = '0;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            bank_elig[b] = reset && !Bank_busy[b] && (occ_cnt[b] == '0);
        end
    end

    // Per-bank round-robin: first matching requester scanning upward from rr_ptr
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = '0;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            grant_src[b] = '0;
        end
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            if (bank_elig[b]) begin
                for (int k = 0; k < int'(NUM_REQ); k++) begin
                    idx = int'(rr_ptr[b]) + k;
                    if (idx >= int'(NUM_REQ)) begin
                        idx = idx - int'(NUM_REQ);
                    end
                    if (!grant_vld[b] && req_valid[idx] &&
                        (req_bank[idx] == BANK_W'(b))) begin
                        grant_vld[b] = 1'b1;
                        grant_src[b] = SRC_W'(idx);
                    end
                end
            end
        end
    end

    // Each requester addresses a single bank, so at most one bank can select it
    always_comb begin
        req_ready = '0;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            if (grant_vld[b]) begin
                req_ready[grant_src[b]] = 1'b1;
            end
        end
    end

    // Command registers, spacing counters and round-robin pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_cmd_valid <= '0;
            bank_cmd_row   <= '0;
            bank_cmd_tag   <= '0;
            bank_cmd_src   <= '0;
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                occ_cnt[b] <= '0;
                rr_ptr[b]  <= '0;
            end
        end else begin
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                bank_cmd_valid[b] <= grant_vld[b];
                if (grant_vld[b]) begin
                    bank_cmd_row[b*ROW_W +: ROW_W] <= req_row[grant_src[b]];
                    bank_cmd_tag[b*TAG_W +: TAG_W] <= req_tag_a[grant_src[b]];
                    bank_cmd_src[b*SRC_W +: SRC_W] <= grant_src[b];
                    occ_cnt[b]                     <= OCC_RELOAD;
                    rr_ptr[b]                      <= (grant_src[b] == SRC_LAST) ?
                                                      '0 : SRC_W'(grant_src[b] + SRC_W'(1));
                end else if (occ_cnt[b] != '0) begin
                    occ_cnt[b] <= occ_cnt[b] - OCC_W'(1);
                end
            end
        end
    end

    // Idle when nothing is being issued and no bank is inside its spacing window
    always_comb begin
        idle = ~|bank_cmd_valid;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            if (occ_cnt[b] != '0) begin
                idle = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_neighbor_bank_arbiter.sv
// Directed testbench for neighbor_bank_arbiter.
// Two instances share one stimulus: dut_a with BANK_LAT=1, dut_b with BANK_LAT=3.
module tb_neighbor_bank_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned NB = 4;
    localparam int unsigned AW = 4;
    localparam int unsigned TW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*TW-1:0] req_tag;
    logic [NB-1:0] busy;

    logic [NR-1:0] ready_a, ready_b;
    logic [NB-1:0] cv_a, cv_b;
    logic [7:0]    row_a, row_b, tag_a, tag_b, src_a, src_b;
    logic          idle_a, idle_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    neighbor_bank_arbiter #(.NUM_REQ(NR), .NUM_BANKS(NB), .ADDR_W(AW), .TAG_W(TW), .BANK_LAT(1)) dut_a (
        .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_tag(req_tag),
        .req_ready(ready_a), .Bank_busy(busy), .bank_cmd_valid(cv_a), .bank_cmd_row(row_a),
        .bank_cmd_tag(tag_a), .bank_cmd_src(src_a), .idle(idle_a)
    );

    neighbor_bank_arbiter #(.NUM_REQ(NR), .NUM_BANKS(NB), .ADDR_W(AW), .TAG_W(TW), .BANK_LAT(3)) dut_b (
        .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_tag(req_tag),
        .req_ready(ready_b), .Bank_busy(busy), .bank_cmd_valid(cv_b), .bank_cmd_row(row_b),
        .bank_cmd_tag(tag_b), .bank_cmd_src(src_b), .idle(idle_b)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [1:0] t);
        req_valid[i]         = 1'b1;
        req_addr[i*AW +: AW] = a;
        req_tag[i*TW +: TW]  = t;
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_addr  = '0;
        req_tag   = '0;
    endtask

    task automatic do_reset();
        clear_req();
        busy  = '0;
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_req();
        busy  = '0;
        rst_n = 1'b0;
        set_req(0, 4'b1001, 2'd2);
        next_cycle();
        next_cycle();
        checks++; if (ready_a !== 4'b0000) begin errors++; $display("FAIL reset_ready_a: got %b want 0000", ready_a); end
        checks++; if (ready_b !== 4'b0000) begin errors++; $display("FAIL reset_ready_b: got %b want 0000", ready_b); end
        checks++; if (cv_a !== 4'b0000) begin errors++; $display("FAIL reset_cmd_valid: got %b want 0000", cv_a); end
        checks++; if (row_a !== 8'h00) begin errors++; $display("FAIL reset_row: got %h want 00", row_a); end
        checks++; if (tag_a !== 8'h00) begin errors++; $display("FAIL reset_tag: got %h want 00", tag_a); end
        checks++; if (src_a !== 8'h00) begin errors++; $display("FAIL reset_src: got %h want 00", src_a); end
        checks++; if (idle_a !== 1'b1) begin errors++; $display("FAIL reset_idle_a: got %b want 1", idle_a); end
        checks++; if (idle_b !== 1'b1) begin errors++; $display("FAIL reset_idle_b: got %b want 1", idle_b); end
        clear_req();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 4'b1001, 2'd2);
        #1;
        checks++; if (ready_a !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", ready_a); end
        checks++; if (cv_a !== 4'b0000) begin errors++; $display("FAIL single_no_early_cmd: got %b want 0000", cv_a); end
        next_cycle();
        clear_req();
        checks++; if (cv_a !== 4'b0100) begin errors++; $display("FAIL single_cmd_valid: got %b want 0100", cv_a); end
        checks++; if (row_a[4 +: 2] !== 2'b01) begin errors++; $display("FAIL single_row: got %b want 01", row_a[4 +: 2]); end
        checks++; if (tag_a[4 +: 2] !== 2'd2) begin errors++; $display("FAIL single_tag: got %0d want 2", tag_a[4 +: 2]); end
        checks++; if (src_a[4 +: 2] !== 2'd0) begin errors++; $display("FAIL single_src: got %0d want 0", src_a[4 +: 2]); end
        checks++; if (idle_a !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", idle_a); end
        next_cycle();
        checks++; if (cv_a !== 4'b0000) begin errors++; $display("FAIL single_strobe_width: got %b want 0000", cv_a); end
        checks++; if (row_a[4 +: 2] !== 2'b01) begin errors++; $display("FAIL single_row_hold: got %b want 01", row_a[4 +: 2]); end
        checks++; if (idle_a !== 1'b1) begin errors++; $display("FAIL single_idle_after: got %b want 1", idle_a); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 4'(4 + i), 2'(i));
        for (int c = 0; c < 5; c++) begin
            exp = 4'(1 << (c % 4));
            #1;
            checks++; if (ready_a !== exp) begin errors++; $display("FAIL rr_ready c%0d: got %b want %b", c, ready_a, exp); end
            next_cycle();
            checks++; if (cv_a !== 4'b0010) begin errors++; $display("FAIL rr_cmd_valid c%0d: got %b want 0010", c, cv_a); end
            checks++; if (src_a[2 +: 2] !== 2'(c % 4)) begin errors++; $display("FAIL rr_src c%0d: got %0d want %0d", c, src_a[2 +: 2], c % 4); end
        end
        clear_req();
    endtask

    task automatic test_parallel();
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 4'((i << 2) | 3), 2'(3 - i));
        #1;
        checks++; if (ready_a !== 4'b1111) begin errors++; $display("FAIL par_ready_a: got %b want 1111", ready_a); end
        checks++; if (ready_b !== 4'b1111) begin errors++; $display("FAIL par_ready_b: got %b want 1111", ready_b); end
        next_cycle();
        clear_req();
        checks++; if (cv_a !== 4'b1111) begin errors++; $display("FAIL par_cmd_valid_a: got %b want 1111", cv_a); end
        checks++; if (cv_b !== 4'b1111) begin errors++; $display("FAIL par_cmd_valid_b: got %b want 1111", cv_b); end
        checks++; if (src_a !== 8'hE4) begin errors++; $display("FAIL par_src_a: got %h want e4", src_a); end
        checks++; if (src_b !== 8'hE4) begin errors++; $display("FAIL par_src_b: got %h want e4", src_b); end
        checks++; if (row_a !== 8'hFF) begin errors++; $display("FAIL par_row: got %h want ff", row_a); end
        checks++; if (tag_a !== 8'h1B) begin errors++; $display("FAIL par_tag: got %h want 1b", tag_a); end
    endtask

    task automatic test_spacing();
        logic [3:0] exp_b [5];
        logic [3:0] exp_a [5];
        exp_b = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
        exp_a = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
        do_reset();
        set_req(0, 4'b0000, 2'd1);
        set_req(1, 4'b0001, 2'd2);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (ready_b !== exp_b[c]) begin errors++; $display("FAIL space_ready_b c%0d: got %b want %b", c, ready_b, exp_b[c]); end
            checks++; if (ready_a !== exp_a[c]) begin errors++; $display("FAIL space_ready_a c%0d: got %b want %b", c, ready_a, exp_a[c]); end
            if (c == 1) begin
                checks++; if (cv_b !== 4'b0001) begin errors++; $display("FAIL space_cmd0: got %b want 0001", cv_b); end
                checks++; if (src_b[1:0] !== 2'd0) begin errors++; $display("FAIL space_src0: got %0d want 0", src_b[1:0]); end
            end
            if (c == 2) begin
                checks++; if (cv_b !== 4'b0000) begin errors++; $display("FAIL space_gap_valid: got %b want 0000", cv_b); end
                checks++; if (idle_b !== 1'b0) begin errors++; $display("FAIL space_idle_occ: got %b want 0", idle_b); end
            end
            if (c == 4) begin
                checks++; if (cv_b !== 4'b0001) begin errors++; $display("FAIL space_cmd1: got %b want 0001", cv_b); end
                checks++; if (src_b[1:0] !== 2'd1) begin errors++; $display("FAIL space_src1: got %0d want 1", src_b[1:0]); end
            end
            next_cycle();
        end
        clear_req();
    endtask

    task automatic test_busy();
        do_reset();
        set_req(1, 4'b1100, 2'd3);
        set_req(0, 4'b0010, 2'd1);
        busy[3] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (ready_a !== 4'b0001) begin errors++; $display("FAIL busy_ready c%0d: got %b want 0001", c, ready_a); end
            next_cycle();
            checks++; if (cv_a[3] !== 1'b0) begin errors++; $display("FAIL busy_no_cmd c%0d: got %b want 0", c, cv_a[3]); end
        end
        busy[3] = 1'b0;
        #1;
        checks++; if (ready_a !== 4'b0011) begin errors++; $display("FAIL busy_release_ready: got %b want 0011", ready_a); end
        next_cycle();
        clear_req();
        checks++; if (cv_a !== 4'b1001) begin errors++; $display("FAIL busy_release_cmd: got %b want 1001", cv_a); end
        checks++; if (src_a[6 +: 2] !== 2'd1) begin errors++; $display("FAIL busy_release_src: got %0d want 1", src_a[6 +: 2]); end
        checks++; if (tag_a[6 +: 2] !== 2'd3) begin errors++; $display("FAIL busy_release_tag: got %0d want 3", tag_a[6 +: 2]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(2, 4'b0000, 2'd0);
        #1;
        checks++; if (ready_a !== 4'b0100) begin errors++; $display("FAIL mid_ready: got %b want 0100", ready_a); end
        next_cycle();
        clear_req();
        checks++; if (cv_a !== 4'b0001) begin errors++; $display("FAIL mid_cmd: got %b want 0001", cv_a); end
        rst_n = 1'b0;
        set_req(0, 4'b0000, 2'd0);
        #1;
        checks++; if (cv_a !== 4'b0000) begin errors++; $display("FAIL mid_async_clear: got %b want 0000", cv_a); end
        checks++; if (idle_b !== 1'b1) begin errors++; $display("FAIL mid_idle_in_reset: got %b want 1", idle_b); end
        checks++; if (ready_a !== 4'b0000) begin errors++; $display("FAIL mid_ready_in_reset: got %b want 0000", ready_a); end
        next_cycle();
        clear_req();
        rst_n = 1'b1;
        #1;
        checks++; if (idle_a !== 1'b1) begin errors++; $display("FAIL mid_idle_after: got %b want 1", idle_a); end
        set_req(0, 4'b0000, 2'd0);
        set_req(3, 4'b0011, 2'd1);
        #1;
        checks++; if (ready_a !== 4'b0001) begin errors++; $display("FAIL mid_rr_restart_a: got %b want 0001", ready_a); end
        checks++; if (ready_b !== 4'b0001) begin errors++; $display("FAIL mid_rr_restart_b: got %b want 0001", ready_b); end
        next_cycle();
        clear_req();
        checks++; if (src_a[1:0] !== 2'd0) begin errors++; $display("FAIL mid_src_after: got %0d want 0", src_a[1:0]); end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_req();
        busy = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_parallel();
        test_spacing();
        test_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neighbor_bank_arbiter.md
# neighbor_bank_arbiter

Shares the `Num_Banks_Neighbor` neighbor-memory banks among several independent request streams, such as per-PE neighbor fetch units or multiple neighbor FIFO drains. Each requester presents one `{PE_tag, addr}` request. The arbiter grants at most one request per bank per cycle, using round-robin priority kept separately for each bank. It enforces a minimum issue spacing per bank and honours the external `Bank_busy` signal. Granted requests leave as registered per-bank commands that drive the neighbor bank controllers.

## Interface
- NUM_REQ, default 4: number of requesters, must be ≥2.
- NUM_BANKS, default 4: number of banks; equals `Num_Banks_Neighbor`; power of two.
- ADDR_W, default 4: request address width; upper log2(NUM_BANKS) bits select the bank, the remaining lower bits form the row.
- TAG_W, default 2: PE_tag width.
- BANK_LAT, default 2: minimum cycles between two issues to the same bank, must be ≥1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  request present, one bit per requester.
- req_addr  in  NUM_REQ*ADDR_W  request address; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_tag  in  NUM_REQ*TAG_W  PE_tag for each requester.
- req_ready  out  NUM_REQ  grant; a transfer occurs when valid&ready in the same cycle.
- Bank_busy  in  NUM_BANKS  external busy flag from each bank controller.
- bank_cmd_valid  out  NUM_BANKS  registered command strobe, one cycle wide.
- bank_cmd_row  out  NUM_BANKS*(ADDR_W-log2(NUM_BANKS))  row address of the command.
- bank_cmd_tag  out  NUM_BANKS*TAG_W  PE_tag of the command.
- bank_cmd_src  out  NUM_BANKS*log2(NUM_REQ)  index of the granted requester.
- idle  out  1  high when no bank command is valid and every occupancy counter is 0.

## Operation
- Bank decode: bank(i) = req_addr_i[ADDR_W-1 -: log2(NUM_BANKS)]; row(i) = req_addr_i[ADDR_W-log2(NUM_BANKS)-1:0]. The two fields do not overlap.
- Per-bank state:
  - occ_cnt[b], width log2(BANK_LAT)+1.
  - rr_ptr[b], width log2(NUM_REQ).
- Bank b is eligible in a cycle when reset is high, Bank_busy[b]==0 and occ_cnt[b]==0.
- Arbitration is combinational within the cycle.
  - For each eligible bank b, candidates are the requesters i with req_valid[i] and bank(i)==b.
  - The winner is the first candidate found scanning from rr_ptr[b] upward, wrapping modulo NUM_REQ.
  - req_ready[i] is 1 only for winners.
  - Each requester targets one bank, so it can win at most one grant per cycle.
  - Banks arbitrate independently, so up to NUM_BANKS grants can occur in the same cycle.
- On a grant to requester w for bank b, at the next posedge:
  - bank_cmd_valid[b]=1.
  - row, tag and src are taken from w.
  - occ_cnt[b]=BANK_LAT-1.
  - rr_ptr[b]=(w+1) mod NUM_REQ.
- For a bank without a grant, at the next posedge:
  - bank_cmd_valid[b]=0.
  - row, tag and src hold their previous values.
  - occ_cnt[b] decrements if it is nonzero.
  - rr_ptr[b] holds.
- req_ready does not depend on req_ready itself. It must not combinationally depend on bank_cmd outputs, only on registered state, req_valid, req_addr and Bank_busy.
- A request that is not granted stays pending with no time limit. Requesters must hold addr and tag stable while valid is high.

## Timing
- Reset (reset==0, asynchronous assertion, synchronous-safe release). During reset:
  - bank_cmd_valid=0, bank_cmd_row=0, bank_cmd_tag=0, bank_cmd_src=0.
  - occ_cnt=0, rr_ptr=0 for every bank.
  - req_ready is forced to 0.
  - idle=1.
- Latency: grant in cycle t produces bank_cmd_valid in cycle t+1 with the matching row, tag and src. The grant-to-command latency is exactly 1 cycle.
- Issue spacing: with continuous demand, bank b issues every BANK_LAT cycles (grants at t, t+BANK_LAT, …). BANK_LAT=1 allows back-to-back grants every cycle.
- Bank_busy is sampled in the same cycle as arbitration. A bank that is busy grants nothing. Its occ_cnt keeps decrementing and its rr_ptr holds.
- Simultaneous events:
  - Requests to different banks in the same cycle are all granted, as long as each bank is eligible.
  - When requests collide on the same bank, one is granted and the others retry.
- Wrap-around: rr_ptr goes from NUM_REQ-1 to 0.
- Reset mid-operation clears pending command strobes and counters immediately. Requests must be re-presented after release.
- idle is combinational from registered state.

## Test plan
1. Single request: req 0 sends addr=4'b1001, tag=2 while all banks are idle. Required: req_ready[0]=1 in cycle t; in cycle t+1, bank_cmd_valid[2]=1, row=2'b01, tag=2, src=0; all other banks stay invalid.
2. Round-robin: requesters 0–3 all target bank 1 continuously with BANK_LAT=1. Required: grants in the order 0,1,2,3,0 on consecutive cycles; src sequence on bank 1 is 0,1,2,3,0.
3. Parallel banks: requesters 0–3 target banks 0–3 respectively in one cycle. Required: all four req_ready bits are 1, and four bank_cmd_valid pulses appear at t+1.
4. Spacing: BANK_LAT=3, two requesters on bank 0. Required: grants at t and t+3; req_ready stays 0 at t+1 and t+2.
5. External busy: hold Bank_busy[3]=1 for 5 cycles while req 1 targets bank 3. Required: no grant during those cycles; grant in the first cycle after Bank_busy[3] returns to 0.
6. Reset mid-operation: assert reset the cycle after a grant. Required: bank_cmd_valid drops to 0 immediately; after release, idle=1 and rr_ptr restarts so requester 0 wins first.
